// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants, the sequential divider's state
// encoding and the default operand width.
package alu_pkg;

    localparam int unsigned DivWidth = 32;

    // ALU opcodes; 5'b00101..5'b01111 are the shift and logic group (shr..log_not).
    localparam logic [4:0] OpAdd    = 5'b00001;
    localparam logic [4:0] OpSub    = 5'b00010;
    localparam logic [4:0] OpMul    = 5'b00011;
    localparam logic [4:0] OpDiv    = 5'b00100;
    localparam logic [4:0] OpShr    = 5'b00101;
    localparam logic [4:0] OpLogNot = 5'b01111;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFix  = 2'd2,
        StDone = 2'd3
    } div_state_e;

endpackage

// File: rtl/alu_seq_div_if.sv
// Request/response bundle between the ALU issue logic and the sequential divider.
//   start, sgn, A, B : request (driven by master)
//   busy, done, dz, C: status and {remainder, quotient} result (driven by slave)
interface alu_seq_div_if #(
    parameter int unsigned WIDTH = alu_pkg::DivWidth
);
    logic               start;
    logic               sgn;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic               busy;
    logic               done;
    logic               dz;
    logic [2*WIDTH-1:0] C;

    modport master (
        output start, sgn, A, B,
        input  busy, done, dz, C
    );

    modport slave (
        input  start, sgn, A, B,
        output busy, done, dz, C
    );
endinterface

// File: rtl/div_step.sv
// One radix-2 restoring division iteration on magnitudes.
//   rem_i     : current partial remainder (always < divisor_i)
//   dvd_msb_i : next dividend bit shifted in
//   divisor_i : divisor magnitude
//   rem_o     : next partial remainder
//   q_o       : quotient bit produced by this iteration
module div_step
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DivWidth
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             dvd_msb_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);
    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] diff;

    always_comb begin
        rem_shift = {rem_i, dvd_msb_i};
        diff      = rem_shift - {1'b0, divisor_i};
        // rem_i < divisor keeps rem_shift < 2*divisor, so the top bit of the
        // WIDTH+1 difference is exactly the borrow (rem_shift < divisor).
        q_o       = ~diff[WIDTH];
        rem_o     = q_o ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    end
endmodule

// File: rtl/alu_seq_div.sv
// Multi-cycle signed/unsigned integer divider for the ALU div opcode.
// Fixed latency: start accepted at edge E0, done pulses after edge E0+WIDTH+1.
//   clk : rising-edge clock
//   clr : asynchronous active-low reset
//   bus : slave side of alu_seq_div_if (start/sgn/A/B in, busy/done/dz/C out)
// C = {remainder, quotient}; C and dz hold until the next result is written.
module alu_seq_div
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DivWidth
) (
    input  logic          clk,
    input  logic          clr,
    alu_seq_div_if.slave  bus
);
    localparam int unsigned      CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0]  CntLast = CntW'(WIDTH - 1);

    div_state_e         state_q;
    logic [WIDTH-1:0]   dvd_q;      // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0]   dvs_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   a_raw_q;    // remainder reported on divide-by-zero
    logic               q_neg_q;
    logic               r_neg_q;
    logic               dz_pend_q;
    logic [CntW-1:0]    cnt_q;
    logic               busy_q;
    logic               done_q;
    logic               dz_q;
    logic [2*WIDTH-1:0] c_q;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   rem_nxt;
    logic               q_bit;

    always_comb begin
        a_neg   = bus.sgn & bus.A[WIDTH-1];
        b_neg   = bus.sgn & bus.B[WIDTH-1];
        // -0x80..0 wraps to 0x80..0, which is the correct unsigned magnitude.
        a_mag   = a_neg ? -bus.A : bus.A;
        b_mag   = b_neg ? -bus.B : bus.B;
        quo_fix = q_neg_q ? -dvd_q : dvd_q;
        rem_fix = r_neg_q ? -rem_q : rem_q;
    end

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i     (rem_q),
        .dvd_msb_i (dvd_q[WIDTH-1]),
        .divisor_i (dvs_q),
        .rem_o     (rem_nxt),
        .q_o       (q_bit)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= StIdle;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            a_raw_q   <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            dz_pend_q <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            c_q       <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        dvd_q     <= a_mag;
                        dvs_q     <= b_mag;
                        a_raw_q   <= bus.A;
                        q_neg_q   <= a_neg ^ b_neg;
                        r_neg_q   <= a_neg;
                        dz_pend_q <= (bus.B == '0);
                        rem_q     <= '0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= StRun;
                    end
                end
                StRun: begin
                    rem_q <= rem_nxt;
                    dvd_q <= {dvd_q[WIDTH-2:0], q_bit};
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == CntLast) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    dz_q    <= dz_pend_q;
                    c_q     <= dz_pend_q ? {a_raw_q, {WIDTH{1'b1}}} : {rem_fix, quo_fix};
                    done_q  <= 1'b1;
                    state_q <= StDone;
                end
                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.dz   = dz_q;
    assign bus.C    = c_q;
endmodule

// File: tb/tb_alu_seq_div.sv
// Scoreboard bench for alu_seq_div: requests push the expected result from a
// plain-arithmetic reference into a queue; a monitor pops and compares on done.
module tb_alu_seq_div;
    localparam int unsigned W = 32;

    typedef struct {
        logic [63:0] c;
        logic        dz;
        int unsigned at;
        int unsigned id;
    } exp_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    alu_seq_div_if #(.WIDTH(W)) bus ();

    alu_seq_div #(
        .WIDTH (W)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    exp_t        sb_q[$];
    exp_t        e;
    int unsigned cyc      = 0;
    int unsigned id_n     = 0;
    int          n_vec    = 0;
    int          n_err    = 0;
    bit          chk_idle = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: truncating division; remainder takes the dividend's sign.
    function automatic logic [64:0] ref_div(bit s, logic [31:0] a, logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(bit s, logic [31:0] a, logic [31:0] b);
        int unsigned t;
        logic [64:0] r;
        exp_t        x;
        t = 0;
        while (bus.busy && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (bus.busy) begin
            n_vec++;
            n_err++;
            $display("FAIL busy timeout: busy still %b, required 0", bus.busy);
            return;
        end
        r         = ref_div(s, a, b);
        bus.sgn   = s;
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        x.c  = r[63:0];
        x.dz = r[64];
        x.at = cyc + 34;
        x.id = id_n;
        id_n++;
        sb_q.push_back(x);
        @(posedge clk); #1;
        bus.start = 1'b0;
        // Operands change while busy; the result must not follow them.
        bus.A     = $urandom();
        bus.B     = $urandom();
        bus.sgn   = 1'($urandom_range(0, 1));
        check("busy after accept", 64'(bus.busy), 64'd1);
    endtask

    task automatic pulse_ignored(logic [31:0] a, logic [31:0] b);
        bus.sgn   = 1'b0;
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Monitor
    always @(negedge clk) begin
        if (clr) begin
            if (chk_idle) begin
                check("busy after done", 64'(bus.busy), 64'd0);
                check("done width", 64'(bus.done), 64'd0);
                chk_idle = 1'b0;
            end
            if (bus.done) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected done: got done=1, required no result pending");
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("C#%0d", e.id), bus.C, e.c);
                    check($sformatf("dz#%0d", e.id), 64'(bus.dz), 64'(e.dz));
                    check($sformatf("latency#%0d", e.id), 64'(cyc), 64'(e.at));
                    check($sformatf("busy at done#%0d", e.id), 64'(bus.busy), 64'd1);
                end
                chk_idle = 1'b1;
            end
        end else begin
            chk_idle = 1'b0;
        end
    end

    initial begin
        logic [31:0] ra, rb;
        bit          rs;
        int unsigned t;

        bus.start = 1'b0;
        bus.sgn   = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        #2 clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset dz", 64'(bus.dz), 64'd0);
        check("reset C", bus.C, 64'd0);
        @(negedge clk) clr = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        issue(1'b0, 32'd100, 32'd7);
        issue(1'b1, 32'hFFFF_FF9C, 32'd7);
        issue(1'b1, 32'd100, 32'hFFFF_FFF9);
        issue(1'b0, 32'hFFFF_FFFF, 32'd2);
        issue(1'b1, 32'hFFFF_FFFF, 32'd2);
        issue(1'b1, 32'd5, 32'd0);
        issue(1'b0, 32'hDEAD_BEEF, 32'd0);
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);

        // start during RUN is ignored
        issue(1'b0, 32'd1000, 32'd10);
        repeat (5) begin @(posedge clk); #1; end
        pulse_ignored(32'd9, 32'd3);

        // start on the done cycle is ignored, one cycle later accepted
        issue(1'b1, 32'hFFFF_FFCE, 32'd6);
        t = 0;
        while (!bus.done && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!bus.done) begin
            n_vec++;
            n_err++;
            $display("FAIL done timeout: done %b, required 1", bus.done);
        end else begin
            pulse_ignored(32'd77, 32'd0);
        end
        issue(1'b0, 32'd9, 32'd3);

        // Randomized
        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom();
            rb = $urandom();
            case ($urandom_range(0, 5))
                0: rb = $urandom_range(1, 15);
                1: rb = 32'd0;
                2: ra = 32'h8000_0000;
                3: rb = 32'hFFFF_FFFF;
                4: ra = $urandom_range(0, 100);
                default: ;
            endcase
            issue(rs, ra, rb);
        end

        // Reset mid-operation
        issue(1'b0, 32'd123456, 32'd7);
        repeat (13) begin @(posedge clk); #1; end
        clr = 1'b0;
        #1;
        check("midreset busy", 64'(bus.busy), 64'd0);
        check("midreset done", 64'(bus.done), 64'd0);
        check("midreset dz", 64'(bus.dz), 64'd0);
        check("midreset C", bus.C, 64'd0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) clr = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        issue(1'b1, 32'hFFFF_FFF9, 32'd2);

        // Drain
        t = 0;
        while (sb_q.size() != 0 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (sb_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain timeout: %0d results pending, required 0", sb_q.size());
        end
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
